zero_mac: RTL and testbench

ZERO_MAC -- requirements
Module: zero_mac

---
 rtl/zero_mac.sv | 138 +++++++++++++
 tb/tb_zero_mac.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/zero_mac.sv
// Eight-tap FIR numerator (zero section) built around one shared multiplier.
// Each accepted sample takes 8 MAC cycles plus 1 output cycle, giving a fixed 10-cycle cadence.
module zero_mac #(
   parameter int NTAP = 8,
   parameter int DW   = 12,
   parameter int OW   = 26
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 din_valid,
   input  logic signed [DW-1:0] Xin,
   output logic signed [OW-1:0] Xout,
   output logic                 dout_valid,
   output logic                 busy,
   output logic                 ovr
);

   localparam int KW = (NTAP > 1) ? $clog2(NTAP) : 1;
   localparam int CW = 12;
   localparam int PW = DW + CW;

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic signed [DW-1:0]   r_x [NTAP];
   logic [KW-1:0]          r_k;
   logic signed [OW-1:0]   r_acc;
   logic signed [OW-1:0]   r_xout;
   logic                   r_dout_valid;
   logic                   r_ovr;

   logic                   w_accept;
   logic                   w_last;
   logic signed [CW-1:0]   w_coef;
   logic signed [DW-1:0]   w_x;
   logic signed [PW-1:0]   w_prod;
   logic signed [OW-1:0]   w_prod_ext;

   // Symmetric low-pass numerator; taps sum to 256 so DC gain is exactly 2^8.
   function automatic logic signed [CW-1:0] coef(input logic [KW-1:0] k);
      case (int'(k))
         0:       coef = 12'sd2;
         1:       coef = 12'sd14;
         2:       coef = 12'sd42;
         3:       coef = 12'sd70;
         4:       coef = 12'sd70;
         5:       coef = 12'sd42;
         6:       coef = 12'sd14;
         7:       coef = 12'sd2;
         default: coef = 12'sd0;
      endcase
   endfunction

   assign w_accept   = (r_state == IDLE) && din_valid;
   assign w_last     = (r_k == KW'(NTAP - 1));
   assign w_coef     = coef(r_k);
   assign w_x        = r_x[r_k];
   assign w_prod     = w_x * w_coef;
   assign w_prod_ext = {{(OW-PW){w_prod[PW-1]}}, w_prod};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      busy         = 1'b0;
      case (r_state)
         IDLE: begin
            if (din_valid) w_state_next = MAC;
         end
         MAC: begin
            busy = 1'b1;
            if (w_last) w_state_next = DONE;
         end
         DONE: begin
            busy         = 1'b1;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Delay line only moves on an accepted sample, so overrun strobes leave it intact.
   genvar gi;
   generate
      for (gi = 0; gi < NTAP; gi++) begin : g_tap
         if (gi == 0) begin : g_head
            always_ff @(posedge clk or posedge rst) begin
               if (rst)           r_x[gi] <= '0;
               else if (w_accept) r_x[gi] <= Xin;
            end
         end else begin : g_body
            always_ff @(posedge clk or posedge rst) begin
               if (rst)           r_x[gi] <= '0;
               else if (w_accept) r_x[gi] <= r_x[gi-1];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc        <= '0;
         r_k          <= '0;
         r_xout       <= '0;
         r_dout_valid <= 1'b0;
         r_ovr        <= 1'b0;
      end else begin
         r_dout_valid <= 1'b0;
         if (din_valid && (r_state != IDLE)) r_ovr <= 1'b1;
         case (r_state)
            IDLE: begin
               if (din_valid) begin
                  r_acc <= '0;
                  r_k   <= '0;
               end
            end
            MAC: begin
               r_acc <= r_acc + w_prod_ext;
               r_k   <= w_last ? '0 : r_k + 1'b1;
            end
            DONE: begin
               r_xout       <= r_acc;
               r_dout_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign Xout       = r_xout;
   assign dout_valid = r_dout_valid;
   assign ovr        = r_ovr;

endmodule

// File: tb/tb_zero_mac.sv
// Directed bench for zero_mac: vector table for impulse/step/full-scale sequences,
// plus hand-written latency, overrun and mid-MAC reset sequences.
module tb_zero_mac;

   localparam int DW = 12;
   localparam int OW = 26;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 din_valid = 1'b0;
   logic signed [DW-1:0] Xin = '0;
   logic signed [OW-1:0] Xout;
   logic                 dout_valid;
   logic                 busy;
   logic                 ovr;

   int n_cmp = 0;
   int n_bad = 0;

   zero_mac #(.NTAP(8), .DW(DW), .OW(OW)) dut (
      .clk(clk), .rst(rst), .din_valid(din_valid), .Xin(Xin),
      .Xout(Xout), .dout_valid(dout_valid), .busy(busy), .ovr(ovr)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit                   rst_first;
      logic signed [DW-1:0] x;
      logic signed [OW-1:0] exp;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit r, input int x, input int e);
      vec_t v;
      v.rst_first = r;
      v.x         = DW'(x);
      v.exp       = OW'(e);
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input longint got, input longint exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end else begin
         $display("ok   %s: %0d", name, got);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Strobes one sample and waits (bounded) for the result; lat = negedges after the accept edge.
   task automatic do_sample(input int x, output longint y, output int lat);
      @(negedge clk);
      din_valid = 1'b1;
      Xin       = DW'(x);
      @(posedge clk);
      #1 din_valid = 1'b0;
      lat = -1;
      y   = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (dout_valid) begin
            lat = n;
            y   = longint'(Xout);
            break;
         end
      end
   endtask

   initial begin
      longint y;
      int     lat;
      int     seen;

      // Impulse of 100
      add(1, 100, 200);  add(0, 0, 1400); add(0, 0, 4200); add(0, 0, 7000);
      add(0, 0, 7000);   add(0, 0, 4200); add(0, 0, 1400); add(0, 0, 200);
      add(0, 0, 0);
      // Negative full-scale step
      add(1, -2048, -4096);   add(0, -2048, -32768);  add(0, -2048, -118784);
      add(0, -2048, -262144); add(0, -2048, -405504); add(0, -2048, -491520);
      add(0, -2048, -520192); add(0, -2048, -524288); add(0, -2048, -524288);
      // Positive full-scale step
      add(1, 2047, 4094);     add(0, 2047, 32752);    add(0, 2047, 118726);
      add(0, 2047, 262016);   add(0, 2047, 405306);   add(0, 2047, 491280);
      add(0, 2047, 519938);   add(0, 2047, 524032);

      // Reset state
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("reset_xout", Xout, 0);
      check("reset_dout_valid", dout_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_ovr", ovr, 0);
      @(negedge clk);
      rst = 1'b0;

      foreach (tbl[i]) begin
         if (tbl[i].rst_first) do_reset();
         do_sample(int'(tbl[i].x), y, lat);
         check($sformatf("vec%0d_x%0d_xout", i, tbl[i].x), y, longint'(tbl[i].exp));
         check($sformatf("vec%0d_latency", i), lat, 10);
      end
      check("no_ovr_at_10_spacing", ovr, 0);

      // Latency and busy/dout_valid timing around one sample
      do_reset();
      @(negedge clk);
      din_valid = 1'b1;
      Xin       = 12'sd100;
      @(posedge clk);
      #1 din_valid = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (n == 1)  check("lat_busy_after_T1", busy, 1);
         if (n == 9)  check("lat_dv_low_before_T9", dout_valid, 0);
         if (n == 9)  check("lat_busy_at_T8", busy, 1);
         if (n == 10) check("lat_dv_high_after_T9", dout_valid, 1);
         if (n == 10) check("lat_xout", Xout, 200);
         if (n == 11) check("lat_dv_low_after_T10", dout_valid, 0);
         if (n == 11) check("lat_busy_low_after_T10", busy, 0);
         if (n == 12) check("lat_xout_held", Xout, 200);
      end

      // Overrun: second strobe three edges after the first is dropped
      do_reset();
      check("ovr_clear_after_reset", ovr, 0);
      @(negedge clk);
      din_valid = 1'b1;
      Xin       = 12'sd100;
      @(posedge clk);
      #1 din_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      din_valid = 1'b1;
      Xin       = 12'sd500;
      @(posedge clk);
      #1 din_valid = 1'b0;
      lat = -1;
      y   = 0;
      for (int n = 4; n <= 20; n++) begin
         @(negedge clk);
         if (dout_valid) begin
            lat = n;
            y   = longint'(Xout);
            break;
         end
      end
      check("ovr_set", ovr, 1);
      check("ovr_first_xout", y, 200);
      check("ovr_first_latency", lat, 10);
      do_sample(0, y, lat);
      check("ovr_next_xout", y, 1400);
      check("ovr_sticky", ovr, 1);

      // Reset mid-MAC aborts the sample
      do_reset();
      @(negedge clk);
      din_valid = 1'b1;
      Xin       = 12'sd100;
      @(posedge clk);
      #1 din_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_xout", Xout, 0);
      check("midrst_dout_valid", dout_valid, 0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      for (int n = 0; n < 15; n++) begin
         @(negedge clk);
         if (dout_valid) seen++;
      end
      check("midrst_no_pulse", seen, 0);
      check("midrst_ovr", ovr, 0);
      do_sample(100, y, lat);
      check("midrst_next_xout", y, 200);
      check("midrst_next_latency", lat, 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
